// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core. Sequences each instruction
// through fetch/decode/execute/memory/writeback over a shared memory port,
// stalls on mem_ready, resolves BEQ/BNE and traps on illegal encodings or
// memory wait timeouts. Control outputs are decoded from the current state.
module multicycle_controller #(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = $clog2(WAIT_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    // A disabled timeout still needs a 1-bit counter to stay well-formed.
    localparam int unsigned CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BRANCH   = 4'd11,
        S_TRAP     = 4'd15
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          mem_timeout_q, mem_timeout_d;
    logic          waiting_c;
    logic          wait_expired_c;

    // Last permitted not-ready cycle of a memory wait.
    assign wait_expired_c = (WAIT_TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and control decode from the current state.
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        mem_timeout_d = mem_timeout_q;
        waiting_c     = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;

        unique case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                waiting_c = 1'b1;
                adr_src   = 1'b0;
                mem_read  = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALU_ADD;
                    result_src = RES_ALU;
                    state_d    = S_DECODE;
                end else if (wait_expired_c) begin
                    state_d       = S_TRAP;
                    mem_timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target is computed here into ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH: begin
                        if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                waiting_c = 1'b1;
                adr_src   = 1'b1;
                mem_read  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired_c) begin
                    state_d       = S_TRAP;
                    mem_timeout_d = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                waiting_c = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expired_c) begin
                    state_d       = S_TRAP;
                    mem_timeout_d = 1'b1;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC takes the jump target from ALUOut; ALUWB then writes oldPC+4.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = (funct3 == F3_BEQ) ? zero : ~zero;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // Consecutive not-ready counter for the memory waiting states.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || mem_ready) begin
            cnt_d = '0;
        end else if (waiting_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State, counter and sticky trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RST;
            cnt_q         <= '0;
            illegal_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            illegal_q     <= illegal_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign illegal     = illegal_q;
    assign mem_timeout = mem_timeout_q;
    assign state_o     = 4'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a table-driven instruction-sequence model
// checked against the DUT every cycle, plus directed literal checks.
module tb_multicycle_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal, mem_timeout;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    multicycle_controller #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
        .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Control word: {pc_write, ir_write, adr_src, mem_read, mem_write,
    //                reg_write, result_src, alu_src_a, alu_src_b, alu_op}
    function automatic logic [13:0] cw(input bit pcw, input bit irw, input bit adr,
                                       input bit mr, input bit mw, input bit rw,
                                       input bit [1:0] rs, input bit [1:0] asa,
                                       input bit [1:0] asb, input bit [1:0] aop);
        return {pcw, irw, adr, mr, mw, rw, rs, asa, asb, aop};
    endfunction

    logic [13:0] base [16];

    initial begin
        for (int i = 0; i < 16; i++) base[i] = '0;
        base[1]  = cw(0,0,0,1,0,0, 2'd0, 2'd0, 2'd0, 2'd0);
        base[2]  = cw(0,0,0,0,0,0, 2'd0, 2'd1, 2'd1, 2'd0);
        base[3]  = cw(0,0,0,0,0,0, 2'd0, 2'd2, 2'd1, 2'd0);
        base[4]  = cw(0,0,1,1,0,0, 2'd0, 2'd0, 2'd0, 2'd0);
        base[5]  = cw(0,0,0,0,0,1, 2'd1, 2'd0, 2'd0, 2'd0);
        base[6]  = cw(0,0,1,0,1,0, 2'd0, 2'd0, 2'd0, 2'd0);
        base[7]  = cw(0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 2'd2);
        base[8]  = cw(0,0,0,0,0,0, 2'd0, 2'd2, 2'd1, 2'd2);
        base[9]  = cw(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 2'd0);
        base[10] = cw(1,0,0,0,0,0, 2'd0, 2'd1, 2'd2, 2'd0);
        base[11] = cw(0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 2'd1);
    end

    function automatic logic [13:0] exp_ctrl(input int st, input logic rdy,
                                             input logic z, input logic [2:0] f3);
        logic [13:0] w;
        w = base[st];
        if (st == 1 && rdy) w = w | cw(1,1,0,0,0,0, 2'd2, 2'd0, 2'd2, 2'd0);
        if (st == 11) w[13] = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
        return w;
    endfunction

    function automatic int decode_target(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011, 7'b0100011: return 3;
            7'b0110011:             return 7;
            7'b0010011:             return 8;
            7'b1101111:             return 10;
            7'b1100011:             return (f3 == 3'b000 || f3 == 3'b001) ? 11 : 15;
            default:                return 15;
        endcase
    endfunction

    // Reference model: instruction step sequence with wait accounting.
    int m_state = 0;
    int m_wait  = 0;
    bit m_ill   = 0;
    bit m_to    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_wait = 0; m_ill = 0; m_to = 0;
        end else begin
            int nxt;
            bit waits;
            int after;
            waits = (m_state == 1 || m_state == 4 || m_state == 6);
            after = (m_state == 1) ? 2 : ((m_state == 4) ? 5 : 1);
            nxt = m_state;
            case (m_state)
                0:         nxt = 1;
                2: begin
                    nxt = decode_target(opcode, funct3);
                    if (nxt == 15) m_ill = 1;
                end
                3:         nxt = opcode[5] ? 6 : 4;
                5, 9, 11:  nxt = 1;
                7, 8, 10:  nxt = 9;
                default:   nxt = m_state;
            endcase
            if (waits) begin
                if (mem_ready) begin
                    nxt = after;
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (TO != 0 && m_wait == TO) begin
                        nxt = 15; m_to = 1; m_wait = 0;
                    end
                end
            end else begin
                m_wait = 0;
            end
            m_state = nxt;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [13:0] dw, ew;
        dw = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
              result_src, alu_src_a, alu_src_b, alu_op};
        ew = rst_n ? exp_ctrl(m_state, mem_ready, zero, funct3) : 14'd0;
        chk("model_ctrl", 32'(dw), 32'(ew));
        chk("model_state", 32'(state_o), 32'(m_state));
        chk("model_illegal", 32'(illegal), 32'(m_ill));
        chk("model_timeout", 32'(mem_timeout), 32'(m_to));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("in_reset_state", 32'(state_o), 0);
        rst_n = 1'b1;
        // add: 0,1,2,7,9,1
        opcode = 7'b0110011; mem_ready = 1'b1;
        chk("add_rst", 32'(state_o), 0);
        chk("add_rst_pcw", 32'(pc_write), 0);
        tick(); chk("add_fetch", 32'(state_o), 1);
        chk("add_fetch_pcw", 32'(pc_write), 1);
        chk("add_fetch_irw", 32'(ir_write), 1);
        tick(); chk("add_decode", 32'(state_o), 2);
        tick(); chk("add_execr", 32'(state_o), 7);
        chk("add_execr_rw", 32'(reg_write), 0);
        tick(); chk("add_aluwb", 32'(state_o), 9);
        chk("add_aluwb_rw", 32'(reg_write), 1);
        chk("add_aluwb_pcw", 32'(pc_write), 0);
        tick(); chk("add_back_fetch", 32'(state_o), 1);

        // lw with three not-ready cycles
        opcode = 7'b0000011;
        tick(); chk("lw_decode", 32'(state_o), 2);
        tick(); chk("lw_memadr", 32'(state_o), 3);
        mem_ready = 1'b0;
        tick(); chk("lw_memread1", 32'(state_o), 4);
        chk("lw_mr", 32'(mem_read), 1);
        chk("lw_adr", 32'(adr_src), 1);
        tick(); chk("lw_memread2", 32'(state_o), 4);
        tick(); chk("lw_memread3", 32'(state_o), 4);
        tick(); chk("lw_memread4", 32'(state_o), 4);
        mem_ready = 1'b1;
        tick(); chk("lw_memwb", 32'(state_o), 5);
        chk("lw_res", 32'(result_src), 1);
        chk("lw_rw", 32'(reg_write), 1);
        tick(); chk("lw_fetch", 32'(state_o), 1);
        chk("lw_no_to", 32'(mem_timeout), 0);

        // beq taken
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        tick(); tick(); chk("beq_state", 32'(state_o), 11);
        chk("beq_pcw", 32'(pc_write), 1);
        tick();
        // bne with zero=1 not taken, zero=0 taken
        funct3 = 3'b001;
        tick(); tick(); chk("bne_state", 32'(state_o), 11);
        chk("bne_pcw_z1", 32'(pc_write), 0);
        zero = 1'b0; #1;
        chk("bne_pcw_z0", 32'(pc_write), 1);
        tick(); chk("bne_fetch", 32'(state_o), 1);
        // illegal branch funct3
        funct3 = 3'b010;
        tick(); chk("bad_br_decode", 32'(state_o), 2);
        tick(); chk("bad_br_trap", 32'(state_o), 15);
        chk("bad_br_ill", 32'(illegal), 1);
        tick(); chk("bad_br_hold", 32'(state_o), 15);
        chk("bad_br_pcw", 32'(pc_write), 0);
        rst_n = 1'b0; #1;
        chk("bad_br_rst_state", 32'(state_o), 0);
        chk("bad_br_rst_ill", 32'(illegal), 0);
        tick(); rst_n = 1'b1;
        tick(); chk("rst_to_fetch", 32'(state_o), 1);

        // opcode 0 -> trap
        opcode = 7'b0000000; funct3 = 3'b000;
        tick(); chk("op0_decode", 32'(state_o), 2);
        tick(); chk("op0_trap", 32'(state_o), 15);
        repeat (3) tick();
        chk("op0_hold", 32'(state_o), 15);
        chk("op0_ill", 32'(illegal), 1);
        chk("op0_rw", 32'(reg_write), 0);
        rst_n = 1'b0; #1;
        chk("op0_rst_ill", 32'(illegal), 0);
        tick(); rst_n = 1'b1;
        tick();

        // sw timeout
        opcode = 7'b0100011;
        tick(); chk("sw_decode", 32'(state_o), 2);
        tick(); chk("sw_memadr", 32'(state_o), 3);
        mem_ready = 1'b0;
        tick(); chk("sw_mw1", 32'(mem_write), 1);
        tick(); tick();
        tick(); chk("sw_w4_state", 32'(state_o), 6);
        chk("sw_w4_mw", 32'(mem_write), 1);
        tick(); chk("sw_trap", 32'(state_o), 15);
        chk("sw_to", 32'(mem_timeout), 1);
        chk("sw_trap_mw", 32'(mem_write), 0);
        tick(); chk("sw_trap_mw2", 32'(mem_write), 0);
        rst_n = 1'b0; #1;
        chk("sw_rst_to", 32'(mem_timeout), 0);
        tick(); rst_n = 1'b1; mem_ready = 1'b1;
        tick();

        // reset mid-MEMWRITE
        tick(); tick(); mem_ready = 1'b0;
        tick(); chk("mid_mw", 32'(mem_write), 1);
        tick();
        rst_n = 1'b0; #1;
        chk("mid_rst_mw", 32'(mem_write), 0);
        chk("mid_rst_state", 32'(state_o), 0);
        tick(); tick(); rst_n = 1'b1;
        chk("mid_rel_state", 32'(state_o), 0);
        tick(); chk("mid_rel_fetch", 32'(state_o), 1);

        // fetch timeout: ready still low
        tick(); tick();
        tick(); chk("fetch_w4", 32'(state_o), 1);
        chk("fetch_w4_mr", 32'(mem_read), 1);
        tick(); chk("fetch_trap", 32'(state_o), 15);
        chk("fetch_to", 32'(mem_timeout), 1);
        rst_n = 1'b0; #1;
        tick(); rst_n = 1'b1; mem_ready = 1'b1;
        tick();

        // addi then jal
        opcode = 7'b0010011;
        tick(); tick(); chk("addi_execi", 32'(state_o), 8);
        tick(); tick(); chk("addi_fetch", 32'(state_o), 1);
        opcode = 7'b1101111;
        tick(); tick(); chk("jal_state", 32'(state_o), 10);
        chk("jal_pcw", 32'(pc_write), 1);
        tick(); chk("jal_aluwb", 32'(state_o), 9);
        tick(); chk("jal_fetch", 32'(state_o), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
